// File: rtl/fpmul_stream_pkg.sv
// Shared types, IEEE-754 field positions and helpers for the streaming multiplier.
package fpmul_stream_pkg;

  typedef enum logic {INIT, RUN} state_t;

  localparam int FP_W    = 32;
  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;

  // Exponent all ones marks Inf or NaN.
  function automatic logic fp_is_exc(input logic [FP_W-1:0] v);
    return &v[EXP_MSB:EXP_LSB];
  endfunction

endpackage

// File: rtl/FPmul.sv
// Single-precision multiplier core: round-to-nearest-even, denormals flushed to zero,
// result delayed by LATENCY clock cycles.
module FPmul
  import fpmul_stream_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic [FP_W-1:0] a_i,
  input  logic [FP_W-1:0] b_i,
  output logic [FP_W-1:0] z_o
);

  logic              sign;
  logic [47:0]       prod;
  logic [23:0]       mant;
  logic              guard, sticky;
  logic [24:0]       mant_r;
  logic signed [9:0] exp_sum, exp_r;
  logic [22:0]       frac;
  logic [FP_W-1:0]   z_c;
  logic [FP_W-1:0]   pipe_q [LATENCY];

  always_comb begin
    sign    = a_i[31] ^ b_i[31];
    prod    = {1'b1, a_i[22:0]} * {1'b1, b_i[22:0]};
    exp_sum = $signed({2'b00, a_i[30:23]}) + $signed({2'b00, b_i[30:23]});
    if (prod[47]) begin
      mant   = prod[47:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      exp_r  = exp_sum - 10'sd126;
    end else begin
      mant   = prod[46:23];
      guard  = prod[22];
      sticky = |prod[21:0];
      exp_r  = exp_sum - 10'sd127;
    end
    mant_r = {1'b0, mant} + {24'd0, guard & (sticky | mant[0])};
    // Rounding carry-out renormalises to 1.0 with the exponent bumped.
    if (mant_r[24]) exp_r = exp_r + 10'sd1;
    frac = mant_r[24] ? mant_r[23:1] : mant_r[22:0];

    if ((a_i[30:23] == 8'hFF && a_i[22:0] != '0) || (b_i[30:23] == 8'hFF && b_i[22:0] != '0))
      z_c = 32'h7FC0_0000;
    else if (a_i[30:23] == 8'hFF || b_i[30:23] == 8'hFF)
      z_c = (a_i[30:23] == 8'h00 || b_i[30:23] == 8'h00) ? 32'h7FC0_0000 : {sign, 8'hFF, 23'd0};
    else if (a_i[30:23] == 8'h00 || b_i[30:23] == 8'h00)
      z_c = {sign, 31'd0};
    else if (exp_r >= 10'sd255)
      z_c = {sign, 8'hFF, 23'd0};
    else if (exp_r <= 10'sd0)
      z_c = {sign, 31'd0};
    else
      z_c = {sign, exp_r[7:0], frac};
  end

  always_ff @(posedge clk) begin
    pipe_q[0] <= z_c;
    for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign z_o = pipe_q[LATENCY-1];

endmodule

// File: rtl/fpmul_res_fifo.sv
// First-word-fall-through result FIFO; head data and valid come straight from registers.
module fpmul_res_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_rd;

  assign rd_valid_o = (count_q != '0);
  assign rd_data_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_rd    = rd_en_i & rd_valid_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en_i) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
      if (do_rd)   rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
      case ({wr_en_i, do_rd})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/fpmul_stream.sv
// Multi-lane streaming wrapper around FPmul: credits reserve FIFO space at issue time,
// so the free-running core never needs to stall.
module fpmul_stream
  import fpmul_stream_pkg::*;
#(
  parameter int LANES      = 1,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [FP_W*LANES-1:0]           in_a,
  input  logic [FP_W*LANES-1:0]           in_b,
  input  logic [TAG_W-1:0]                in_tag,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [FP_W*LANES-1:0]           out_z,
  output logic [TAG_W-1:0]                out_tag,
  output logic [LANES-1:0]                out_exc,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] inflight
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int DW    = FP_W * LANES + TAG_W;
  localparam logic [CNT_W-1:0] FULL_CREDITS = CNT_W'(FIFO_DEPTH);

  if (LANES < 1 || LANES > 8 || LATENCY < 1 || FIFO_DEPTH < 1 || TAG_W < 1) begin : g_bad_params
    $error("fpmul_stream: parameter out of range");
  end

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       credits_q, credits_d;
  logic [LATENCY-1:0]     vld_q;
  logic [TAG_W-1:0]       tag_q [LATENCY];
  logic [FP_W*LANES-1:0]  core_z;
  logic [DW-1:0]          fifo_rd_data;
  logic                   accept, pop;

  assign accept   = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign inflight = FULL_CREDITS - credits_q;

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      INIT:    state_d = RUN;
      RUN:     in_ready = (credits_q != '0);
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    credits_d = credits_q;
    if (flush)
      credits_d = FULL_CREDITS;
    else if (accept && !pop)
      credits_d = credits_q - 1'b1;
    else if (pop && !accept)
      credits_d = credits_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= INIT;
      credits_q <= FULL_CREDITS;
      vld_q     <= '0;
    end else begin
      state_q   <= state_d;
      credits_q <= credits_d;
      vld_q     <= flush ? '0 : ((vld_q << 1) | LATENCY'(accept));
    end
  end

  // Tags need no reset: they are only consumed alongside a set valid bit.
  always_ff @(posedge clk) begin
    tag_q[0] <= in_tag;
    for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    FPmul #(.LATENCY(LATENCY)) u_mul (
      .clk (clk),
      .a_i (in_a[FP_W*gi +: FP_W]),
      .b_i (in_b[FP_W*gi +: FP_W]),
      .z_o (core_z[FP_W*gi +: FP_W])
    );
    assign out_exc[gi] = out_valid & fp_is_exc(out_z[FP_W*gi +: FP_W]);
  end

  fpmul_res_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .wr_en_i    (vld_q[LATENCY-1]),
    .wr_data_i  ({tag_q[LATENCY-1], core_z}),
    .rd_en_i    (pop),
    .rd_data_o  (fifo_rd_data),
    .rd_valid_o (out_valid)
  );

  assign out_z   = fifo_rd_data[FP_W*LANES-1:0];
  assign out_tag = fifo_rd_data[DW-1 -: TAG_W];

endmodule

// File: tb/tb_fpmul_stream.sv
// Scoreboard bench for fpmul_stream: expected products come from real arithmetic
// rounded to single precision; a negedge monitor checks every popped result set.
`timescale 1ns/1ps
module tb_fpmul_stream;

  localparam int LANES      = 2;
  localparam int LATENCY    = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int TAG_W      = 4;
  localparam int ZW         = 32 * LANES;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b1;
  logic             in_ready, out_valid;
  logic [ZW-1:0]    in_a = '0, in_b = '0, out_z;
  logic [TAG_W-1:0] in_tag = '0, out_tag;
  logic [LANES-1:0] out_exc;
  logic [2:0]       inflight;

  always #5 clk = ~clk;

  fpmul_stream #(.LANES(LANES), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_tag(out_tag), .out_exc(out_exc), .inflight(inflight)
  );

  typedef struct packed {
    logic [ZW-1:0]    a;
    logic [ZW-1:0]    b;
    logic [ZW-1:0]    z;
    logic [TAG_W-1:0] tag;
  } item_t;

  item_t            sb[$];
  item_t            pend[$];
  int               total = 0;
  int               bad = 0;
  int               n_pop = 0;
  logic [TAG_W-1:0] next_tag = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Single-precision bits to a real value (denormals read as zero).
  function automatic real sp_to_real(input logic [31:0] v);
    logic [63:0] d;
    if (v[30:23] == 8'h00)      d = {v[31], 63'd0};
    else if (v[30:23] == 8'hFF) d = {v[31], 11'h7FF, 52'd0};
    else                        d = {v[31], 11'(int'(v[30:23]) + 896), v[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // Exact real product, rounded to nearest-even single precision.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] d;
    logic [24:0] keep;
    logic        s;
    int          se;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {s, 8'hFF, 23'd0};
    d    = $realtobits(sp_to_real(a) * sp_to_real(b));
    se   = int'(d[62:52]) - 1023 + 127;
    keep = {2'b01, d[51:29]};
    if (d[28] && ((d[27:0] != '0) || keep[0])) keep = keep + 25'd1;
    if (keep[24]) begin
      keep = keep >> 1;
      se++;
    end
    if (se >= 255) return {s, 8'hFF, 23'd0};
    if (se <= 0)   return {s, 31'd0};
    return {s, se[7:0], keep[22:0]};
  endfunction

  function automatic logic [LANES-1:0] exp_exc(input logic [ZW-1:0] z);
    logic [LANES-1:0] e;
    for (int i = 0; i < LANES; i++) e[i] = &z[32*i+23 +: 8];
    return e;
  endfunction

  function automatic logic [31:0] rand_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  task automatic add_op(input logic [ZW-1:0] a, input logic [ZW-1:0] b);
    item_t it;
    it.a = a;
    it.b = b;
    it.tag = next_tag;
    for (int i = 0; i < LANES; i++) it.z[32*i +: 32] = ref_mul(a[32*i +: 32], b[32*i +: 32]);
    pend.push_back(it);
    next_tag = next_tag + 1'b1;
  endtask

  task automatic add_rand(input int n);
    for (int k = 0; k < n; k++) add_op({rand_fp(), rand_fp()}, {rand_fp(), rand_fp()});
  endtask

  // Offer pending operations one per cycle until all taken or max_cyc elapses.
  task automatic run_ops(input int max_cyc, input bit rand_ready, output int acc, output int used);
    logic r;
    acc  = 0;
    used = 0;
    while (pend.size() != 0 && used < max_cyc) begin
      in_a     = pend[0].a;
      in_b     = pend[0].b;
      in_tag   = pend[0].tag;
      in_valid = 1'b1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      used++;
      if (r) begin
        sb.push_back(pend.pop_front());
        acc++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_drained"}, 64'(sb.size()), 64'd0);
    check({name, "_inflight"}, 64'(inflight), 64'd0);
  endtask

  always @(negedge clk) begin : monitor
    item_t e;
    string s;
    if (rst_n && out_valid && out_ready) begin
      n_pop++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got tag=%0d z=%h, required no result", out_tag, out_z);
      end else begin
        e = sb.pop_front();
        check("result_z", 64'(out_z), 64'(e.z));
        check("result_tag", 64'(out_tag), 64'(e.tag));
        check("result_exc", 64'(out_exc), 64'(exp_exc(e.z)));
        s = $sformatf("pop tag=%0d", out_tag);
        for (int i = 0; i < LANES; i++)
          s = {s, $sformatf(" lane%0d A=%f B=%f Z=%f", i, sp_to_real(e.a[32*i +: 32]),
                            sp_to_real(e.b[32*i +: 32]), sp_to_real(out_z[32*i +: 32]))};
        $display("%s", s);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, required finish within 1ms");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, used, n, pops0;

    // Reset release
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_in_ready_cycle0", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_inflight", 64'(inflight), 64'd0);
    @(posedge clk);
    #1;
    check("rst_in_ready_cycle1", 64'(in_ready), 64'd1);
    check("rst_out_valid_cycle1", 64'(out_valid), 64'd0);
    check("rst_inflight_cycle1", 64'(inflight), 64'd0);

    // Single op with latency measurement
    next_tag = 4'd5;
    add_op({rand_fp(), 32'h4000_0000}, {rand_fp(), 32'h4040_0000});
    run_ops(10, 1'b0, acc, used);
    check("single_accepted", 64'(acc), 64'd1);
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("single_latency_edges", 64'(n), 64'(LATENCY + 1));
    check("single_z_lane0", 64'(out_z[31:0]), 64'h40C0_0000);
    check("single_tag", 64'(out_tag), 64'd5);
    check("single_exc_lane0", 64'(out_exc[0]), 64'd0);
    drain("single");

    // Back-to-back streaming
    next_tag = '0;
    for (int i = 0; i < 4; i++) add_op({32'h7F80_0000, 32'h3FC0_0000}, {32'h3F80_0000, 32'hC000_0000});
    add_rand(20);
    run_ops(100, 1'b0, acc, used);
    check("stream_cycles", 64'(used), 64'd24);
    repeat (LATENCY + 1) @(posedge clk);
    #1;
    check("stream_output_rate", 64'(sb.size()), 64'd0);
    drain("stream");

    // Backpressure
    out_ready = 1'b0;
    add_rand(10);
    run_ops(10, 1'b0, acc, used);
    check("bp_accepted", 64'(acc), 64'(FIFO_DEPTH));
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_inflight", 64'(inflight), 64'(FIFO_DEPTH));
    pend.delete();
    out_ready = 1'b1;
    drain("bp");
    check("bp_in_ready_after", 64'(in_ready), 64'd1);

    // Flush with three in flight
    out_ready = 1'b0;
    add_rand(3);
    run_ops(10, 1'b0, acc, used);
    check("flush_pre_accepted", 64'(acc), 64'd3);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    sb.delete();
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_inflight", 64'(inflight), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    pops0 = n_pop;
    add_op({32'h3F80_0000, 32'h3F80_0000}, {32'h3F80_0000, 32'h3F80_0000});
    run_ops(10, 1'b0, acc, used);
    repeat (10) @(posedge clk);
    #1;
    check("flush_single_result", 64'(n_pop - pops0), 64'd1);
    drain("flush");

    // Simultaneous accept and pop at FIFO_DEPTH-1 in flight
    out_ready = 1'b0;
    add_rand(FIFO_DEPTH - 1);
    run_ops(10, 1'b0, acc, used);
    repeat (LATENCY + 1) @(posedge clk);
    #1;
    check("sim_pre_inflight", 64'(inflight), 64'(FIFO_DEPTH - 1));
    check("sim_pre_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    add_rand(1);
    run_ops(5, 1'b0, acc, used);
    check("sim_single_cycle", 64'(used), 64'd1);
    check("sim_inflight", 64'(inflight), 64'(FIFO_DEPTH - 1));
    check("sim_in_ready", 64'(in_ready), 64'd1);
    drain("sim");

    // Reset mid-stream
    add_rand(5);
    run_ops(20, 1'b0, acc, used);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready_after", 64'(in_ready), 64'd1);
    check("midrst_inflight", 64'(inflight), 64'd0);
    pops0 = n_pop;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_stale", 64'(n_pop - pops0), 64'd0);

    // Random traffic with random backpressure
    add_rand(40);
    run_ops(400, 1'b1, acc, used);
    check("rand_all_accepted", 64'(acc), 64'd40);
    out_ready = 1'b1;
    drain("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
